rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that returns a shared resource to one of N requesters as a one-hot grant. It is the grant-distribution end of a request path where requests are OR-combined.
- Sits between N requesting blocks and one shared resource. busy is the OR of all grants.
- Fully synchronous; all outputs are registered.

Parameters:
N, 4, number of requesters; legal range 2..16
HOLD_MAX, 8, maximum consecutive grant cycles per holder (used only with ARB_TIMEOUT_EN); legal range 2..255

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  N  request lines; requester i holds req[i] high for as long as it needs the resource
grant  output  N  one-hot grant, or all zero
grant_id  output  $clog2(N)  index of current holder; 0 when grant_valid=0
grant_valid  output  1  high when any grant bit is set
busy  output  1  OR of grant bits; identical to grant_valid
timeout_err  output  1  one-cycle pulse when a grant is forcibly revoked (0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (reset=1 at a clock edge): grant=0, grant_id=0, grant_valid=0, busy=0, timeout_err=0. State goes to IDLE. Round-robin pointer last=N-1, so req[0] has highest priority after reset. Reset overrides all other activity, including mid-grant; the grant drops at that same edge.
- Pick function: from the current req (excluding the holder when releasing or revoking), choose the lowest index i such that i is after last in wrap-around order (last+1, ..., N-1, 0, ..., last).
- IDLE:
  - If req != 0, grant pick() at the next edge, update last=pick, and go to GRANTED. Latency from req rising to grant is 1 cycle.
  - If req == 0, stay in IDLE with outputs zero.
- GRANTED (holder h = grant_id):
  - req[h]=1: keep the grant unchanged. Other requests cannot preempt the holder.
  - req[h]=0 and other requests pending: hand over to pick() at the next edge, with no idle gap. Update last.
  - req[h]=0 and no other requests: go to IDLE. Grant goes to 0 at the next edge.
- Grant is never given to a requester whose req was 0 at the sampling edge.
- Exactly zero or one grant bit is set in every cycle. grant_id always encodes the set bit.
- Pointer wraps modulo N. Requests arriving in the same cycle are resolved solely by the pointer order.
- A single-cycle req pulse in IDLE produces a single-cycle grant one cycle later. The grant drops at the following edge because req is then 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: an 8-bit hold counter clears on every new grant and increments each cycle the same holder keeps the grant.
  - A holder may keep the grant for at most HOLD_MAX consecutive cycles.
  - At the edge ending cycle HOLD_MAX with req[h] still 1, the grant is revoked. Arbitration then proceeds as a release by h, excluding h from the pick.
  - timeout_err=1 for exactly the cycle after revocation, concurrent with the new grant or with IDLE.
  - A revoked requester still holding req competes again under normal round-robin order.
- Undefined: no counter logic is present, timeout_err is tied to 0, and the holder keeps the grant indefinitely.

Test Plan:
- reset, then req=0001 at cycle 1 -> cycle 2: grant=0001, grant_id=0, grant_valid=1, busy=1; req=0 at cycle 2 -> cycle 3 grant=0000.
- req=1111 held; each holder drops its req for one cycle after 2 granted cycles, then re-raises it -> grant order 0,1,2,3,0 with no idle cycles between holders.
- Holder 2 active (last=2); req goes from 0100 to 1001 -> next edge grant=1000 (id 3), not 0001.
- reset asserted for one cycle while grant=0100, with req=0110 -> grant=0000 at the reset edge; next edge grant=0010 (pointer back to N-1, so index 1 wins over 2).
- ARB_TIMEOUT_EN, HOLD_MAX=3, req=0011 held -> grant=0001 for exactly 3 cycles; then grant=0010 with timeout_err=1 for one cycle; then grant 1 held for 3 cycles, then back to 0 with another pulse.
- Check every cycle in all scenarios -> grant is one-hot or zero, grant_valid==busy==|grant, and grant_id matches the grant bit.

Source files
------------

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters (master side) and the round-robin arbiter (slave side).
// state_dbg mirrors the arbiter FSM state for checkers: 0 = IDLE, 1 = GRANTED.
//
// Handshake: requester i raises req[i] and holds it while it needs the resource. It owns
// the resource in every cycle where grant[i] is high. It releases by dropping req[i].
// The arbiter never grants a requester whose req was low at the sampling edge.
interface rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           busy;
    logic           timeout_err;
    logic           state_dbg;

    modport master (
        output req,
        input  grant, grant_id, grant_valid, busy, timeout_err, state_dbg
    );

    modport slave (
        input  req,
        output grant, grant_id, grant_valid, busy, timeout_err, state_dbg
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and non-preemptive holding.
// Optional macro ARB_TIMEOUT_EN revokes a grant after HOLD_MAX consecutive cycles.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic      clk,
    input  logic      reset,
    rr_arbiter_if.slave arb
);
    localparam int IDW = $clog2(N);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [N-1:0]   cand;
    logic           pick_found;
    logic [IDW-1:0] pick_id;
    logic           revoke;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       terr_q, terr_d;
`endif

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % N;
        return IDW'(s);
    endfunction

    // The holder is always masked out: on release its req is already 0, on revoke it must lose.
    always_comb begin
        cand = arb.req;
        if (state_q == GRANTED) cand[id_q] = 1'b0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = N; k >= 1; k--) begin
            if (cand[wrap_idx(last_q, k)]) begin
                pick_found = 1'b1;
                pick_id    = wrap_idx(last_q, k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    assign revoke = (state_q == GRANTED) && arb.req[id_q] && (cnt_q == 8'(HOLD_MAX - 1));
`else
    assign revoke = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        if ((state_q == IDLE || !arb.req[id_q] || revoke) && pick_found) begin
            state_d = GRANTED;
            grant_d = N'(1) << pick_id;
            id_d    = pick_id;
            last_d  = pick_id;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end else if (state_q == GRANTED && arb.req[id_q] && !revoke) begin
`ifdef ARB_TIMEOUT_EN
            cnt_d   = cnt_q + 8'd1;
`endif
        end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
        end
`ifdef ARB_TIMEOUT_EN
        terr_d = revoke;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            last_q  <= IDW'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end
    assign arb.timeout_err = terr_q;
`else
    assign arb.timeout_err = 1'b0;
`endif

    assign arb.grant       = grant_q;
    assign arb.grant_id    = id_q;
    assign arb.grant_valid = (state_q == GRANTED);
    assign arb.busy        = (state_q == GRANTED);
    assign arb.state_dbg   = state_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a holder/pointer reference model predicts each registered
// output, a monitor compares one cycle later and also checks the one-hot invariants.
module tb_rr_arbiter;
  localparam int N        = 4;
  localparam int HOLD_MAX = 3;
  localparam int IDW      = $clog2(N);
  localparam int W        = N + IDW + 3;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // reference model: holder index (-1 = none), pointer, cycles held so far minus one
  int m_holder = -1;
  int m_last   = N - 1;
  int m_cnt    = 0;
  bit m_terr   = 1'b0;

  function automatic int pick(input logic [N-1:0] c, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (((c >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic model_update(input bit rst, input logic [N-1:0] r);
    logic [N-1:0] c;
    int p;
    bit holds;
    m_terr = 1'b0;
    if (rst) begin
      m_holder = -1;
      m_last   = N - 1;
      m_cnt    = 0;
    end else if (m_holder < 0) begin
      p = pick(r, m_last);
      if (p >= 0) begin
        m_holder = p; m_last = p; m_cnt = 0;
      end
    end else begin
      holds = ((r >> m_holder) & N'(1)) != '0;
      if (holds && !(TO_EN && m_cnt == HOLD_MAX - 1)) begin
        m_cnt++;
      end else begin
        m_terr = holds;
        c = r & ~(N'(1) << m_holder);
        p = pick(c, m_last);
        if (p >= 0) begin
          m_holder = p; m_last = p; m_cnt = 0;
        end else begin
          m_holder = -1;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] expected();
    logic [N-1:0]   g;
    logic [IDW-1:0] id;
    logic           v;
    g  = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
    id = (m_holder >= 0) ? IDW'(m_holder) : '0;
    v  = (m_holder >= 0);
    return {m_terr, v, v, id, g};
  endfunction

  // driver
  task automatic step(input bit rst, input logic [N-1:0] r);
    @(negedge clk);
    reset   = rst;
    bus.req = r;
    model_update(rst, r);
    exp_q.push_back(expected());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant",       32'(bus.grant),       32'(e[N-1:0]));
        check("grant_id",    32'(bus.grant_id),    32'(e[N+IDW-1:N]));
        check("grant_valid", 32'(bus.grant_valid), 32'(e[N+IDW]));
        check("busy",        32'(bus.busy),        32'(e[N+IDW+1]));
        check("timeout_err", 32'(bus.timeout_err), 32'(e[N+IDW+2]));
        check("onehot",      32'($countones(bus.grant) <= 1), 32'd1);
        check("valid_or",    32'(bus.grant_valid), 32'(|bus.grant));
        check("busy_eq",     32'(bus.busy),        32'(bus.grant_valid));
        if (bus.grant != '0)
          check("id_match", 32'(bus.grant), 32'(N'(1) << bus.grant_id));
      end
    end
  end

  // stimulus
  initial begin
    logic [N-1:0] r;
    reset   = 1'b1;
    bus.req = '0;

    // single request, one-cycle latency, release
    step(1, 4'b0000);
    step(0, 4'b0001);
    step(0, 4'b0000);
    step(0, 4'b0000);

    // all requesting, each holder drops after 2 granted cycles
    step(1, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      r = 4'b1111;
      if (m_holder >= 0 && m_cnt == 1) r = r & ~(N'(1) << m_holder);
      step(0, r);
    end

    // holder 2, then 1001 -> id 3 wins over 0
    step(1, 4'b0000);
    step(0, 4'b0100);
    step(0, 4'b0100);
    step(0, 4'b1001);
    step(0, 4'b0000);

    // reset mid-grant restores pointer
    step(1, 4'b0000);
    step(0, 4'b0100);
    step(0, 4'b0100);
    step(1, 4'b0110);
    step(0, 4'b0110);
    step(0, 4'b0000);

    // long hold by two requesters (revocation when the timeout is built in)
    step(1, 4'b0000);
    for (int i = 0; i < 10; i++) step(0, 4'b0011);
    step(0, 4'b0000);

    // randomized traffic with occasional reset
    r = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 31) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      step($urandom_range(0, 63) == 0, r);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
